// File: rtl/fht_frame_sched_pkg.sv
// Shared FHT frame-scheduler definitions: default address width, error-flag
// bit positions and the scheduler FSM state type.
package fht_frame_sched_pkg;

  localparam int unsigned FHT_A_BIT_DEF = 9;

  localparam int unsigned ERR_FRAME_LEN = 0;
  localparam int unsigned ERR_FHT_TOUT  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_LO,
    ST_RUN,
    ST_UNLOAD
  } fht_sched_state_e;

endpackage

// File: rtl/fht_frame_sched_rd_stage.sv
// Result read-out stage: issues reads to the 1-cycle-latency result memory and
// presents each sample with a valid/ready handshake, flagging the final one.
module fht_rd_stage
  import fht_frame_sched_pkg::*;
#(
  parameter int unsigned A_BIT = FHT_A_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             out_ready,
  output logic             rd_en,
  output logic [A_BIT-1:0] rd_addr,
  output logic             out_valid,
  output logic             out_last,
  output logic             last_hs
);

  localparam logic [A_BIT-1:0] LAST_ADDR = '1;

  logic [A_BIT-1:0] rd_cnt;
  logic             rd_done;

  // A new read refills the output register whenever it is empty or being drained.
  assign rd_en   = en & ~rd_done & (~out_valid | out_ready);
  assign rd_addr = rd_cnt;
  assign last_hs = out_valid & out_last & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt    <= '0;
      rd_done   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (!en) begin
      rd_cnt    <= '0;
      rd_done   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (rd_en) begin
      rd_cnt    <= rd_cnt + A_BIT'(1);
      out_valid <= 1'b1;
      out_last  <= (rd_cnt == LAST_ADDR);
      if (rd_cnt == LAST_ADDR) begin
        rd_done <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/fht_frame_sched.sv
// Frame scheduler around fht_control: loads one N-point frame, starts the
// transform, waits for completion and streams the results out.
module fht_frame_sched
  import fht_frame_sched_pkg::*;
#(
  parameter int unsigned A_BIT    = FHT_A_BIT_DEF,
  parameter int unsigned FHT_TOUT = 65535
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iIN_VALID,
  input  logic             iIN_LAST,
  output logic             oIN_READY,
  output logic             oLOAD_WE,
  output logic [A_BIT-1:0] oLOAD_ADDR,
  output logic             oFHT_START,
  input  logic             iFHT_RDY,
  output logic             oRD_EN,
  output logic [A_BIT-1:0] oRD_ADDR,
  output logic             oOUT_VALID,
  output logic             oOUT_LAST,
  input  logic             iOUT_READY,
  output logic             oBUSY,
  output logic [1:0]       oERR
);

  localparam int unsigned      TW        = $clog2(FHT_TOUT + 1);
  localparam logic [A_BIT-1:0] LAST_ADDR = '1;
  localparam logic [TW-1:0]    TOUT_LAST = TW'(FHT_TOUT - 1);

  fht_sched_state_e state, state_next;
  logic [A_BIT-1:0] load_cnt, load_cnt_next;
  logic [TW-1:0]    tout_cnt, tout_cnt_next;
  logic [1:0]       err, err_next;
  logic             in_ready, in_hs, fht_start, rd_active, last_hs;

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state    <= ST_IDLE;
      load_cnt <= '0;
      tout_cnt <= '0;
      err      <= '0;
    end else begin
      state    <= state_next;
      load_cnt <= load_cnt_next;
      tout_cnt <= tout_cnt_next;
      err      <= err_next;
    end
  end

  always_comb begin
    state_next    = state;
    load_cnt_next = load_cnt;
    tout_cnt_next = tout_cnt;
    err_next      = err;
    in_ready      = 1'b0;
    in_hs         = 1'b0;
    fht_start     = 1'b0;
    rd_active     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (iIN_VALID) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        in_hs    = iIN_VALID;
        if (iIN_VALID) begin
          // A full frame always proceeds; a short one is dropped and loading restarts.
          if (load_cnt == LAST_ADDR) begin
            load_cnt_next = '0;
            state_next    = ST_START;
            if (!iIN_LAST) err_next[ERR_FRAME_LEN] = 1'b1;
          end else if (iIN_LAST) begin
            load_cnt_next           = '0;
            err_next[ERR_FRAME_LEN] = 1'b1;
          end else begin
            load_cnt_next = load_cnt + A_BIT'(1);
          end
        end
      end
      ST_START: begin
        fht_start     = 1'b1;
        tout_cnt_next = '0;
        state_next    = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!iFHT_RDY) begin
          state_next = ST_RUN;
        end else if (tout_cnt == TOUT_LAST) begin
          err_next[ERR_FHT_TOUT] = 1'b1;
          state_next             = ST_IDLE;
        end else begin
          tout_cnt_next = tout_cnt + TW'(1);
        end
      end
      ST_RUN: begin
        if (iFHT_RDY) state_next = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        rd_active = 1'b1;
        if (last_hs) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  fht_rd_stage #(
    .A_BIT(A_BIT)
  ) u_rd_stage (
    .clk      (iCLK),
    .rst_n    (iRESET),
    .en       (rd_active),
    .out_ready(iOUT_READY),
    .rd_en    (oRD_EN),
    .rd_addr  (oRD_ADDR),
    .out_valid(oOUT_VALID),
    .out_last (oOUT_LAST),
    .last_hs  (last_hs)
  );

  assign oIN_READY  = in_ready;
  assign oLOAD_WE   = in_hs;
  assign oLOAD_ADDR = load_cnt;
  assign oFHT_START = fht_start;
  assign oBUSY      = (state != ST_IDLE);
  assign oERR       = err;

endmodule

// File: tb/tb_fht_frame_sched.sv
// Bench for fht_frame_sched: data/result memory and fht_control models, with an
// end-to-end check that each frame's results come back in load order.
module tb_fht_frame_sched;

  localparam int unsigned A_BIT = 9;
  localparam int unsigned N     = 1 << A_BIT;
  localparam int unsigned TOUT  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic             rdy;
  logic             oIN_READY, oLOAD_WE, oFHT_START, oRD_EN, oOUT_VALID, oOUT_LAST, oBUSY;
  logic [A_BIT-1:0] oLOAD_ADDR, oRD_ADDR;
  logic [1:0]       oERR;
  logic [2*A_BIT+8:0] outs;

  logic [15:0] ld_data = '0;
  logic [15:0] mem [N];
  logic [15:0] rd_data;
  logic [15:0] exp_q [$];
  logic [1:0]  exp_err = '0;

  int checks = 0, errors = 0;
  int start_cnt = 0;
  int fht_cnt = 0;
  bit fht_dead = 1'b0;
  int fht_delay = 3, fht_len = 2000;

  fht_frame_sched #(
    .A_BIT   (A_BIT),
    .FHT_TOUT(TOUT)
  ) dut (
    .iCLK      (clk),
    .iRESET    (rst_n),
    .iIN_VALID (in_valid),
    .iIN_LAST  (in_last),
    .oIN_READY (oIN_READY),
    .oLOAD_WE  (oLOAD_WE),
    .oLOAD_ADDR(oLOAD_ADDR),
    .oFHT_START(oFHT_START),
    .iFHT_RDY  (rdy),
    .oRD_EN    (oRD_EN),
    .oRD_ADDR  (oRD_ADDR),
    .oOUT_VALID(oOUT_VALID),
    .oOUT_LAST (oOUT_LAST),
    .iOUT_READY(out_ready),
    .oBUSY     (oBUSY),
    .oERR      (oERR)
  );

  assign outs = {oIN_READY, oLOAD_WE, oFHT_START, oRD_EN, oOUT_VALID, oOUT_LAST,
                 oBUSY, oERR, oLOAD_ADDR, oRD_ADDR};

  always #5 clk = ~clk;

  // Transform modelled as identity: result memory is the data memory.
  always @(posedge clk) begin
    if (oLOAD_WE) mem[oLOAD_ADDR] <= ld_data;
    if (oRD_EN) rd_data <= mem[oRD_ADDR];
  end

  always @(posedge clk) begin
    if (rst_n && oFHT_START) start_cnt <= start_cnt + 1;
  end

  // fht_control model: RDY falls a few cycles after start and stays low fht_len cycles.
  always @(posedge clk) begin
    if (!rst_n) fht_cnt <= 0;
    else if (oFHT_START && !fht_dead) fht_cnt <= 1;
    else if (fht_cnt != 0) fht_cnt <= (fht_cnt >= fht_delay + fht_len) ? 0 : fht_cnt + 1;
  end
  assign rdy = !(fht_cnt > fht_delay && fht_cnt <= fht_delay + fht_len);

  task automatic send_frame(input int len, input bit with_last, input int gap_max);
    int wait_c;
    for (int i = 0; i < len; i++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_last  = with_last && (i == len - 1);
      ld_data  = 16'($urandom);
      #1;
      wait_c = 0;
      while (!oIN_READY && wait_c < 20) begin
        @(negedge clk);
        #1;
        wait_c++;
      end
      checks++;
      if (oIN_READY !== 1'b1) begin
        errors++;
        $display("FAIL load_ready sample %0d: ready=%b want 1", i, oIN_READY);
      end
      checks++;
      if (oLOAD_WE !== 1'b1 || oLOAD_ADDR !== A_BIT'(i)) begin
        errors++;
        $display("FAIL load_strobe sample %0d: we=%b addr=%0d want we=1 addr=%0d",
                 i, oLOAD_WE, oLOAD_ADDR, i);
      end
      exp_q.push_back(ld_data);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain_frame(input int mode);
    int rd_idx = 0, got = 0, cyc = 0, pat = 0;
    bit fin = 1'b0, prev_stall = 1'b0;
    logic [15:0] prev_data = '0, exp_d;
    while (!fin && cyc < 12000) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(1, 0));
        default: begin
          out_ready = (pat % 4 == 0) || (pat % 4 == 3);
          pat++;
        end
      endcase
      #1;
      if (oRD_EN) begin
        checks++;
        if (rd_idx >= N || oRD_ADDR !== A_BIT'(rd_idx)) begin
          errors++;
          $display("FAIL rd_addr read %0d: addr=%0d want %0d", rd_idx, oRD_ADDR, rd_idx);
        end
        rd_idx++;
      end
      if (prev_stall) begin
        checks++;
        if (oOUT_VALID !== 1'b1 || rd_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h want valid=1 data=%h",
                   oOUT_VALID, rd_data, prev_data);
        end
      end
      if (oOUT_VALID && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_extra: data=%h want no sample", rd_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (rd_data !== exp_d || oOUT_LAST !== (exp_q.size() == 0)) begin
            errors++;
            $display("FAIL out_data idx %0d: data=%h last=%b want data=%h last=%b",
                     got, rd_data, oOUT_LAST, exp_d, exp_q.size() == 0);
          end
        end
        got++;
        if (oOUT_LAST) fin = 1'b1;
      end
      prev_stall = oOUT_VALID && !out_ready;
      prev_data  = rd_data;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL drain_timeout: got %0d samples want %0d", got, N);
    end
    checks++;
    if (got != N || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL drain_count: samples=%0d busy=%b want %0d busy=0", got, oBUSY, N);
    end
    checks++;
    if (oERR !== exp_err) begin
      errors++;
      $display("FAIL err_flags: err=%b want %b", oERR, exp_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: %h want 0", outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int s0 = start_cnt;
    fht_dead = 1'b0; fht_delay = 3; fht_len = 2000;
    exp_q.delete();
    send_frame(N, 1'b1, 0);
    checks++;
    if (oFHT_START !== 1'b1) begin
      errors++;
      $display("FAIL start_pulse: start=%b want 1", oFHT_START);
    end
    @(negedge clk);
    checks++;
    if (oFHT_START !== 1'b0) begin
      errors++;
      $display("FAIL start_width: start=%b want 0", oFHT_START);
    end
    drain_frame(0);
    checks++;
    if (start_cnt != s0 + 1) begin
      errors++;
      $display("FAIL start_count: %0d pulses want 1", start_cnt - s0);
    end
  endtask

  task automatic test_backpressure();
    fht_len = 200;
    exp_q.delete();
    send_frame(N, 1'b1, 3);
    drain_frame(2);
    exp_q.delete();
    send_frame(N, 1'b1, 1);
    drain_frame(1);
  endtask

  task automatic test_early_last();
    int s0 = start_cnt;
    exp_q.delete();
    send_frame(100, 1'b1, 2);
    exp_q.delete();
    exp_err[0] = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (oERR !== exp_err || start_cnt != s0 || oIN_READY !== 1'b1 || oBUSY !== 1'b1) begin
      errors++;
      $display("FAIL early_last: err=%b starts=%0d ready=%b busy=%b want err=%b starts=0 ready=1 busy=1",
               oERR, start_cnt - s0, oIN_READY, oBUSY, exp_err);
    end
    send_frame(N, 1'b1, 0);
    drain_frame(0);
    checks++;
    if (start_cnt != s0 + 1) begin
      errors++;
      $display("FAIL early_start_count: %0d pulses want 1", start_cnt - s0);
    end
  endtask

  task automatic test_timeout();
    fht_dead = 1'b1;
    exp_q.delete();
    send_frame(N, 1'b1, 0);
    @(negedge clk);
    repeat (15) @(negedge clk);
    checks++;
    if (oBUSY !== 1'b1 || oERR[1] !== 1'b0) begin
      errors++;
      $display("FAIL tout_early: busy=%b err1=%b at 15 cycles want busy=1 err1=0", oBUSY, oERR[1]);
    end
    @(negedge clk);
    exp_err[1] = 1'b1;
    checks++;
    if (oBUSY !== 1'b0 || oERR !== exp_err) begin
      errors++;
      $display("FAIL tout_hit: busy=%b err=%b at 16 cycles want busy=0 err=%b", oBUSY, oERR, exp_err);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (oRD_EN !== 1'b0 || oOUT_VALID !== 1'b0 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL tout_idle: rd_en=%b valid=%b busy=%b want 0 0 0", oRD_EN, oOUT_VALID, oBUSY);
    end
    fht_dead = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lowc = 0, cyc = 0, strobes = 0;
    fht_len = 300;
    exp_q.delete();
    send_frame(N, 1'b1, 0);
    while (lowc < 20 && cyc < 500) begin
      @(negedge clk);
      if (!rdy) lowc++;
      cyc++;
    end
    checks++;
    if (lowc != 20) begin
      errors++;
      $display("FAIL run_reach: rdy low %0d cycles want 20", lowc);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL run_reset_outputs: %h want 0", outs);
    end
    rst_n = 1'b1;
    exp_err = '0;
    exp_q.delete();
    repeat (50) begin
      @(negedge clk);
      if (oFHT_START || oRD_EN || oOUT_VALID || oBUSY || oLOAD_WE) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: %0d active cycles want 0", strobes);
    end
    send_frame(N, 1'b1, 1);
    drain_frame(1);
  endtask

  task automatic test_missing_last();
    int s0 = start_cnt;
    exp_q.delete();
    send_frame(N, 1'b0, 0);
    exp_err[0] = 1'b1;
    drain_frame(0);
    checks++;
    if (start_cnt != s0 + 1) begin
      errors++;
      $display("FAIL missing_last_start: %0d pulses want 1", start_cnt - s0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_last();
    test_timeout();
    test_reset_mid_run();
    test_missing_last();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fht_frame_sched.md
FHT_FRAME_SCHED -- requirements
Module: fht_frame_sched

Interface
REQ-001 Parameter A_BIT, default 9: address width; frame length N = 2**A_BIT points.
REQ-002 Parameter FHT_TOUT, default 65535: maximum cycles to wait for iFHT_RDY to fall after oFHT_START.
REQ-003 iCLK  in  1  sole clock; all logic on its rising edge.
REQ-004 iRESET  in  1  synchronous, active-low reset.
REQ-005 iIN_VALID  in  1  input sample valid.
REQ-006 iIN_LAST  in  1  marks the last sample of a frame; qualified by iIN_VALID.
REQ-007 oIN_READY  out  1  scheduler accepts an input sample.
REQ-008 oLOAD_WE  out  1  write strobe to the FHT data memory.
REQ-009 oLOAD_ADDR  out  A_BIT  write address to the FHT data memory.
REQ-010 oFHT_START  out  1  one-cycle start pulse to fht_control.
REQ-011 iFHT_RDY  in  1  fht_control ready: high when idle, low while transforming.
REQ-012 oRD_EN  out  1  read strobe to the FHT result memory (1-cycle read latency).
REQ-013 oRD_ADDR  out  A_BIT  read address to the FHT result memory.
REQ-014 oOUT_VALID  out  1  result sample on the memory output is valid.
REQ-015 oOUT_LAST  out  1  qualifies the final result sample of a frame.
REQ-016 iOUT_READY  in  1  downstream accepts a result sample.
REQ-017 oBUSY  out  1  high in every state except IDLE.
REQ-018 oERR  out  2  sticky error flags: [0] frame-length error, [1] FHT timeout.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, START, WAIT_LO, RUN, UNLOAD.
REQ-020 IDLE SHALL go to LOAD when iIN_VALID=1; all strobes are 0 in IDLE.
REQ-021 In LOAD, oIN_READY SHALL be 1; on each iIN_VALID&oIN_READY, oLOAD_WE=1 in the same cycle, oLOAD_ADDR = load counter, and the counter increments.
REQ-022 A handshake with the counter = N-1 SHALL move LOAD to START and clear the counter; a missing iIN_LAST at that point sets oERR[0], and the frame proceeds.
REQ-023 A handshake with iIN_LAST=1 and the counter < N-1 SHALL write the sample, set oERR[0], clear the counter, and keep the FSM in LOAD (frame discarded).
REQ-024 START SHALL assert oFHT_START for exactly one cycle, then go to WAIT_LO.
REQ-025 WAIT_LO SHALL go to RUN when iFHT_RDY=0; after FHT_TOUT cycles without it, it sets oERR[1] and returns to IDLE.
REQ-026 RUN SHALL go to UNLOAD on the first cycle with iFHT_RDY=1; there is no timeout in RUN.
REQ-027 In UNLOAD, oRD_EN = !oOUT_VALID | iOUT_READY; each oRD_EN increments the read counter; oRD_ADDR = read counter.
REQ-028 oOUT_VALID SHALL be set one cycle after oRD_EN; it clears on iOUT_READY when no new read is issued, and holds while iOUT_READY=0.
REQ-029 oOUT_LAST SHALL be 1 together with oOUT_VALID for the sample read at address N-1.
REQ-030 After the read at N-1, no further oRD_EN SHALL be issued; the FSM returns to IDLE on the handshake of the oOUT_LAST sample.
REQ-031 oIN_READY SHALL be 0 in every state except LOAD; inputs arriving outside LOAD are not accepted.
REQ-032 Counters SHALL be A_BIT wide and wrap modulo N; no address ≥ N is issued.
REQ-033 oERR SHALL be cleared only by reset.

Reset
REQ-034 With iRESET=0 at a clock edge, the next state SHALL be IDLE; counters = 0; oIN_READY, oLOAD_WE, oFHT_START, oRD_EN, oOUT_VALID, oOUT_LAST, oBUSY = 0; oERR = 0; oLOAD_ADDR and oRD_ADDR = 0.
REQ-035 A reset in any state, including mid-LOAD or RUN, SHALL abandon the frame with no further strobes; a subsequent frame runs normally.

Structure
REQ-036 The FSM state enum, the A_BIT default, and the error-bit indices SHALL live in the shared FHT package alongside the existing FHT defines.
REQ-037 The output valid/ready stage SHALL be one sub-module, fht_rd_stage: read counter, oRD_EN, oOUT_VALID, oOUT_LAST.
REQ-038 The implementation SHALL be 120-400 lines of RTL, with no memories inside the block.

Verification
REQ-039 Nominal frame: 512 samples with iIN_LAST on the 512th, fht_control model dropping RDY 3 cycles after start for 2000 cycles -> one oFHT_START pulse, then 512 results, addresses 0..511 in order, oOUT_LAST on address 511, oERR=0.
REQ-040 Early last: iIN_LAST on sample 100 -> oERR[0]=1, no oFHT_START; the next 512-sample frame completes normally.
REQ-041 Backpressure: iOUT_READY toggling 1-0-0-1 during UNLOAD -> no sample dropped or duplicated, oOUT_VALID/data held while stalled.
REQ-042 Timeout: FHT_TOUT=16, iFHT_RDY held 1 -> oERR[1]=1 and oBUSY=0 exactly 16 cycles after entering WAIT_LO.
REQ-043 Reset mid-RUN: iRESET=0 for 1 cycle -> all outputs at reset values next cycle; the following frame completes correctly.
